// File: rtl/wbs_ctrl_bridge.sv
// wbs_ctrl_bridge: Wishbone slave for the ANN accelerator (wb bus in/out, mode/debug/start/busy/done control, query/leaf/node write ports, best-array read port)
module wbs_ctrl_bridge #(
  parameter int QUERY_AW = 9,
  parameter int LEAF_AW = 9,
  parameter int BEST_AW = 9,
  parameter int NODE_AW = 6,
  parameter int READ_LAT = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  output logic [1:0]          mode_o,
  output logic                debug_o,
  output logic                fsm_start_o,
  input  logic                fsm_busy_i,
  input  logic                fsm_done_i,
  output logic                query_we_o,
  output logic [QUERY_AW-1:0] query_addr_o,
  output logic [54:0]         query_wdata_o,
  output logic                leaf_we_o,
  output logic [LEAF_AW-1:0]  leaf_addr_o,
  output logic [63:0]         leaf_wdata_o,
  output logic                node_we_o,
  output logic [NODE_AW-1:0]  node_addr_o,
  output logic [21:0]         node_wdata_o,
  output logic                best_re_o,
  output logic [BEST_AW-1:0]  best_addr_o,
  input  logic [63:0]         best_rdata_i
);
  typedef enum logic [1:0] {IDLE, MEMWR, RDWAIT, ACK} state_t;
  localparam int CW = $clog2(READ_LAT + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [15:0] page, off_r;
  logic [31:0] lower, reg_rd;
  logic [63:0] wide;
  logic [1:0] dat_r;
  logic pg_reg, pg_q, pg_l, pg_b, pg_n, pg_mem, req, gate, upper_wr, best_rd;
  logic we_r, sel0_r, reg_r, best_r, gate_r, done, blocked;
  logic in_ack, reg_wr, clr, start_wr, blk_set;
  assign page = wbs_adr_i[31:16];
  assign pg_reg = page == 16'h3000;
  assign pg_q = page == 16'h3001;
  assign pg_l = page == 16'h3002;
  assign pg_b = page == 16'h3003;
  assign pg_n = page == 16'h3004;
  assign pg_mem = pg_q | pg_l | pg_b | pg_n;
  assign req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & (pg_reg | pg_mem);
  assign gate = pg_mem & fsm_busy_i;
  assign upper_wr = wbs_we_i & (((pg_q | pg_l) & wbs_adr_i[2]) | pg_n);
  assign best_rd = pg_b & ~wbs_we_i;
  assign wide = {wbs_dat_i, lower};
  assign reg_rd = off_r == 16'h0 ? {30'b0, mode_o} :
                  off_r == 16'h4 ? {31'b0, debug_o} :
                  off_r == 16'h8 ? {30'b0, blocked, done} :
                  off_r == 16'h10 ? {31'b0, fsm_busy_i} : '0;
  assign in_ack = state == ACK;
  assign reg_wr = in_ack & reg_r & we_r;
  assign clr = reg_wr & off_r == 16'h8;
  assign start_wr = reg_wr & off_r == 16'hC;
  assign blk_set = (state == IDLE & req & gate) | (start_wr & fsm_busy_i);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req) state_nx = gate ? ACK : best_rd ? RDWAIT : upper_wr ? MEMWR : ACK;
      MEMWR: state_nx = wbs_cyc_i ? ACK : IDLE;
      RDWAIT: state_nx = !wbs_cyc_i ? IDLE : cnt == CW'(READ_LAT - 1) ? ACK : RDWAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= state == RDWAIT ? cnt + 1'b1 : '0;
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      mode_o <= '0;
      debug_o <= 1'b0;
      fsm_start_o <= 1'b0;
      query_we_o <= 1'b0;
      query_addr_o <= '0;
      query_wdata_o <= '0;
      leaf_we_o <= 1'b0;
      leaf_addr_o <= '0;
      leaf_wdata_o <= '0;
      node_we_o <= 1'b0;
      node_addr_o <= '0;
      node_wdata_o <= '0;
      best_re_o <= 1'b0;
      best_addr_o <= '0;
      done <= 1'b0;
      blocked <= 1'b0;
      lower <= '0;
      off_r <= '0;
      dat_r <= '0;
      we_r <= 1'b0;
      sel0_r <= 1'b0;
      reg_r <= 1'b0;
      best_r <= 1'b0;
      gate_r <= 1'b0;
    end else begin
      wbs_ack_o <= in_ack & wbs_cyc_i;
      wbs_dat_o <= in_ack & wbs_cyc_i & ~we_r & ~gate_r ?
                   (reg_r ? reg_rd : best_r ? (off_r[2] ? best_rdata_i[63:32] : best_rdata_i[31:0]) : '0) : '0;
      fsm_start_o <= start_wr & ~fsm_busy_i;
      query_we_o <= 1'b0;
      leaf_we_o <= 1'b0;
      node_we_o <= 1'b0;
      best_re_o <= 1'b0;
      done <= fsm_done_i | (done & ~clr);
      blocked <= blk_set | (blocked & ~clr);
      if (reg_wr & off_r == 16'h0 & sel0_r) mode_o <= dat_r;
      if (reg_wr & off_r == 16'h4) debug_o <= dat_r[0];
      if (state == IDLE & req) begin
        off_r <= wbs_adr_i[15:0];
        dat_r <= wbs_dat_i[1:0];
        we_r <= wbs_we_i;
        sel0_r <= wbs_sel_i[0];
        reg_r <= pg_reg;
        best_r <= pg_b;
        gate_r <= gate;
        if (!gate) begin
          if ((pg_q | pg_l) & wbs_we_i & ~wbs_adr_i[2]) lower <= wbs_dat_i;
          if (pg_q & upper_wr) begin
            query_we_o <= 1'b1;
            query_addr_o <= wbs_adr_i[3+QUERY_AW-1:3];
            query_wdata_o <= wide[54:0];
          end
          if (pg_l & upper_wr) begin
            leaf_we_o <= 1'b1;
            leaf_addr_o <= wbs_adr_i[3+LEAF_AW-1:3];
            leaf_wdata_o <= wide;
          end
          if (pg_n & upper_wr) begin
            node_we_o <= 1'b1;
            node_addr_o <= wbs_adr_i[NODE_AW+1:2];
            node_wdata_o <= wbs_dat_i[21:0];
          end
          if (best_rd) begin
            best_re_o <= 1'b1;
            best_addr_o <= wbs_adr_i[3+BEST_AW-1:3];
          end
        end
      end
    end
  end
endmodule
